// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: registered 4-input round-robin valid/ready arbiter feeding the 4:1 mux stage
module rr_arb_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);
    logic [1:0]   last;
    logic [1:0]   gidx;
    logic [W-1:0] gdata;
    logic         load;
    // scan from lowest to highest priority so the nearest requester after last wins
    always_comb begin
        gidx = last;
        for (int k = 4; k > 0; k--)
            gidx = in_valid[last + 2'(k)] ? last + 2'(k) : gidx;
    end
    assign load     = !out_valid || out_ready;
    assign in_ready = (load && |in_valid) ? 4'b0001 << gidx : 4'b0000;
    assign gdata    = gidx == 2'd0 ? in_data0 :
                      gidx == 2'd1 ? in_data1 :
                      gidx == 2'd2 ? in_data2 : in_data3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            last      <= 2'd3;
        end else if (load) begin
            out_valid <= |in_valid;
            if (|in_valid) begin
                out_data <= gdata;
                out_src  <= gidx;
                last     <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_4_1.sv
// tb_rr_arb_4_1: directed and randomized checks of rr_arb_4_1 against a rule-level model
module tb_rr_arb_4_1;
    logic       clk = 0;
    logic       rst_n = 1;
    logic [3:0] in_valid = 0;
    logic [3:0] d [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready = 0;
    int vectors = 0;
    int errs = 0;
    int mlast = 3;
    logic mv = 0;
    logic [3:0] md = 0;
    int ms = 0;
    int pass [4] = '{0, 0, 0, 0};
    int acc_cnt = 0;
    int del_cnt = 0;
    int g_m;
    int g_c;
    logic [3:0] acc = 0;

    always #5 clk = ~clk;

    rr_arb_4_1 #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(d[0]), .in_data1(d[1]), .in_data2(d[2]), .in_data3(d[3]),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    function automatic int grant_of(int l, logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(l + k) % 4]) return (l + k) % 4;
        return -1;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // reference: priority scan from last+1, register loads when empty or draining
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mlast = 3; mv = 0; md = 0; ms = 0; acc_cnt = 0; del_cnt = 0;
            for (int i = 0; i < 4; i++) pass[i] = 0;
        end else begin
            g_m = grant_of(mlast, in_valid);
            if (mv && out_ready) del_cnt++;
            if (!mv || out_ready) begin
                if (g_m >= 0) begin
                    for (int i = 0; i < 4; i++)
                        pass[i] = (i == g_m || !in_valid[i]) ? 0 : pass[i] + 1;
                    mv = 1; md = d[g_m]; ms = g_m; mlast = g_m; acc_cnt++;
                end else mv = 0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            g_c = grant_of(mlast, in_valid);
            chk("in_ready", in_ready, ((!mv || out_ready) && g_c >= 0) ? 4'b0001 << g_c : 4'b0000);
            chk("out_valid", out_valid, mv);
            chk("out_data", out_data, md);
            chk("out_src", out_src, ms);
            for (int j = 0; j < 4; j++) chk("fairness", pass[j] <= 3, 1);
        end
    end

    initial begin
        #1 rst_n = 0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1; out_ready = 1; in_valid = 4'hf;
        d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("rot_src", out_src, k % 4);
        end
        #1 in_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_src", out_src, 0);
        chk("midrst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1; in_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("rot2_src", out_src, k % 4);
            chk("rot2_data", out_data, k % 4 + 1);
        end
        #1 in_valid = 4'b0100; d[2] = 4'hA;
        #1 chk("single_rdy", in_ready, 4'b0100);
        @(posedge clk); #1;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 4'hA);
        chk("single_src", out_src, 2);
        d[2] = 4'h5;
        @(posedge clk); #1;
        chk("single2_valid", out_valid, 1);
        chk("single2_data", out_data, 4'h5);
        in_valid = 4'hf;
        for (int i = 0; i < 4; i++) d[i] = 4'h3;
        @(posedge clk); #1;
        chk("bp_load_data", out_data, 4'h3);
        chk("bp_load_src", out_src, 3);
        out_ready = 0;
        for (int i = 0; i < 4; i++) d[i] = 4'h7;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_rdy", in_ready, 0);
            @(posedge clk); #1;
            chk("bp_data", out_data, 4'h3);
            chk("bp_src", out_src, 3);
        end
        out_ready = 1;
        #1 chk("bp_resume_rdy", in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("bp_resume_src", out_src, 0);
        chk("bp_resume_data", out_data, 4'h7);
        in_valid = 0;
        #1 rst_n = 0;
        @(negedge clk);
        rst_n = 1; in_valid = 4'b1010; d[1] = 4'hC; d[3] = 4'hB;
        for (int k = 0; k < 4; k++) begin
            #1 chk("holes_rdy02", in_ready & 4'b0101, 0);
            @(posedge clk); #1;
            chk("holes_src", out_src, (k % 2 == 1) ? 3 : 1);
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_data", out_data, 4'hB);
        chk("idle_src", out_src, 3);
        in_valid = 4'b1000; d[3] = 4'h9;
        @(posedge clk); #1;
        chk("idle_next_valid", out_valid, 1);
        chk("idle_next_src", out_src, 3);
        chk("idle_next_data", out_data, 4'h9);
        in_valid = 0;
        acc = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) in_valid[i] = 0;
                if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
                    d[i] = 4'($urandom);
                    in_valid[i] = 1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #3 acc = in_ready;
        end
        @(negedge clk); #3;
        chk("conservation", acc_cnt, del_cnt + int'(mv));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/rr_arb_4_1.md
# rr_arb_4_1

Registered 4-input round-robin stream arbiter that sits directly upstream of the 4:1 data mux stage. It picks one of four valid/ready sources each cycle and registers that source's data together with its 2-bit select index. Downstream logic receives one arbitrated beat per cycle under a valid/ready handshake. Fairness comes from a rotating priority pointer, so no valid source waits more than three grants.

## Interface
- W, 4: width of each data word.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  4  bit i set means source i presents a beat.
- in_data0, in_data1, in_data2, in_data3  input  W each  source data words.
- in_ready  output  4  bit i set means source i's beat is accepted this cycle; combinational.
- out_valid  output  1  registered beat available.
- out_data  output  W  registered data of the granted source.
- out_src  output  2  registered index of the granted source; this is the select value for the mux.
- out_ready  input  1  downstream accepts the beat.

## Operation
- Output register: out_valid, out_data, out_src. Pointer register: last[1:0], the index of the last granted source.
- load = !out_valid || out_ready. This means the register is empty or is being drained this cycle.
- Priority order starts at last+1 mod 4 and wraps: last+1, last+2, last+3, last.
- grant = the first index in priority order whose in_valid bit is set. At most one grant bit is ever set.
- in_ready[i] = load && grant[i]. When load is 0, all in_ready bits are 0.
- On a clock edge where load is 1 and any in_valid bit is set:
  - out_data ← in_data of the granted source.
  - out_src ← granted index.
  - out_valid ← 1.
  - last ← granted index.
- On a clock edge where load is 1 and no in_valid bit is set:
  - out_valid ← 0.
  - out_data, out_src and last hold their values.
- On a clock edge where load is 0 (out_valid=1, out_ready=0):
  - All registers hold.
  - out_data and out_src must stay stable until the handshake completes.
- A source that is not granted is not consumed. It keeps its beat and sees in_ready low.
- The pointer advances only on an accepted grant. It never advances on idle cycles or stall cycles.

## Timing
- Reset values (rst_n low, asynchronous, held while low):
  - out_valid=0.
  - out_data=0.
  - out_src=0.
  - last=3, so source 0 has first priority after reset.
  - in_ready=0, because out_valid=0 and no in_valid bits are set.
- Reset asserted mid-operation clears the register immediately. Any beat held in the register is dropped.
- Latency: an input handshake at edge N makes the beat visible on out_* right after edge N, so out_valid is high in cycle N+1.
- Throughput: 1 beat/cycle when out_ready is held high. The output is full and drained in the same cycle, which counts as a load.
- Combinational paths:
  - in_valid → in_ready.
  - out_ready → in_ready.
  - There is no path from in_data to any output except through the register.
- Simultaneous events: when out_ready=1 and a new grant occur in the same cycle, the old beat is consumed and the new beat is loaded on the same edge, with no bubble.
- Fairness bound: a source held valid is granted within 4 accepted beats.

## Test plan
- **Reset check.** Assert rst_n=0 asynchronously in mid-cycle while out_valid=1.
  - Required: out_valid, out_data and out_src read 0 before the next edge.
  - After release with in_valid=4'b1111 and out_ready=1: out_src sequence is 0,1,2,3,0.
- **Single source.** in_valid=4'b0100, in_data2=4'hA, out_ready=1.
  - Required: in_ready=4'b0100, then out_valid=1, out_data=4'hA, out_src=2 on the next cycle.
  - Repeat with in_data2=4'h5: out_data=4'h5 one cycle later, no bubble.
- **Backpressure.** Load out_data=4'h3, then drive out_ready=0 for 3 cycles with in_valid=4'b1111.
  - Required: in_ready=0 throughout; out_data=4'h3 and out_src stay stable; the pointer is unchanged.
  - The first grant after out_ready returns to 1 is last+1.
- **Rotation with holes.** in_valid=4'b1010 constantly, out_ready=1, starting from reset.
  - Required: out_src alternates 1,3,1,3.
  - Required: in_ready[0] and in_ready[2] are never set.
- **Idle drain.** A beat is present and in_valid=0 with out_ready=1.
  - Required: out_valid falls to 0 on the next edge; out_data and out_src hold.
  - Required: the next request from source 3 is granted with out_src=3.
- **Fairness under random stall.** Drive random in_valid (sources hold until accepted), random out_ready, and random data for 10k cycles.
  - Scoreboard: per-source order is preserved, no beat is lost or duplicated, and no waiting source is passed over more than 3 times.
